// File: rtl/queue_packetizer.sv
// Frames bytes popped from the byte queue into USB IN packets of up to MAX_PKT bytes.
// Define QUEUE_PACKETIZER_ZLP_EN to send a zero-length packet after a full packet that drains the queue.
module queue_packetizer #(
    parameter int MAX_PKT = 64,
    parameter int TIMEOUT = 16
) (
    input  logic       r_clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_last,
    output logic       tx_zlp,
    input  logic       tx_ready,
    output logic       busy
);
    localparam int CW = $clog2(MAX_PKT);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PKT - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, HOLD, SEND, ZWAIT, ZSEND} state_t;

    state_t          state_reg;
    logic [CW-1:0]   byte_cnt_reg;
    logic [TW-1:0]   timer_reg;
    logic [7:0]      hold_reg;
    logic            last_reg;

`ifdef QUEUE_PACKETIZER_ZLP_EN
    logic            full_reg;
    logic            tx_zlp_reg;
    assign tx_zlp = tx_zlp_reg;
`else
    assign tx_zlp = 1'b0;
`endif

    always_ff @(posedge r_clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
            timer_reg    <= '0;
            hold_reg     <= '0;
            last_reg     <= 1'b0;
            fifo_rd_en   <= 1'b0;
            tx_valid     <= 1'b0;
            tx_data      <= '0;
            tx_last      <= 1'b0;
            busy         <= 1'b0;
`ifdef QUEUE_PACKETIZER_ZLP_EN
            full_reg     <= 1'b0;
            tx_zlp_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                        state_reg  <= FETCH;
                    end
                end
                FETCH: begin
                    // First FETCH cycle issues the pop; read data lands one cycle later.
                    fifo_rd_en <= 1'b0;
                    if (!fifo_rd_en) begin
                        hold_reg  <= fifo_data;
                        timer_reg <= '0;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (byte_cnt_reg == CNT_LAST || !fifo_empty || timer_reg == TMO_LAST) begin
                        last_reg  <= (byte_cnt_reg == CNT_LAST) || fifo_empty;
                        tx_last   <= (byte_cnt_reg == CNT_LAST) || fifo_empty;
                        tx_valid  <= 1'b1;
                        tx_data   <= hold_reg;
                        state_reg <= SEND;
`ifdef QUEUE_PACKETIZER_ZLP_EN
                        full_reg  <= (byte_cnt_reg == CNT_LAST);
`endif
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid     <= 1'b0;
                        tx_data      <= '0;
                        tx_last      <= 1'b0;
                        byte_cnt_reg <= last_reg ? '0 : byte_cnt_reg + 1'b1;
                        // Mid-packet the queue is known non-empty: HOLD saw a byte behind this one.
                        if (!last_reg || !fifo_empty) begin
                            fifo_rd_en <= 1'b1;
                            state_reg  <= FETCH;
                        end
`ifdef QUEUE_PACKETIZER_ZLP_EN
                        else if (full_reg) begin
                            timer_reg <= '0;
                            state_reg <= ZWAIT;
                        end
`endif
                        else begin
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
`ifdef QUEUE_PACKETIZER_ZLP_EN
                ZWAIT: begin
                    if (!fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        state_reg  <= FETCH;
                    end else if (timer_reg == TMO_LAST) begin
                        tx_valid   <= 1'b1;
                        tx_last    <= 1'b1;
                        tx_zlp_reg <= 1'b1;
                        tx_data    <= '0;
                        state_reg  <= ZSEND;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ZSEND: begin
                    if (tx_ready) begin
                        tx_valid   <= 1'b0;
                        tx_last    <= 1'b0;
                        tx_zlp_reg <= 1'b0;
                        busy       <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
`endif
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_queue_packetizer.sv
// Scoreboard bench for queue_packetizer: a queue model feeds bytes, expected beats are
// derived from packet-size rules, and a negedge monitor checks every accepted beat.
module tb_queue_packetizer;
    localparam int MAX_PKT = 64;
    localparam int TIMEOUT = 16;

    logic       r_clk = 1'b0;
    logic       rst = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_zlp;
    logic       tx_ready = 1'b0;
    logic       busy;

    int checks = 0;
    int passes = 0;
    int ready_mode = 0;

    logic [7:0] mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic [9:0] exp_q [$];

    always #5 r_clk = ~r_clk;

    queue_packetizer #(.MAX_PKT(MAX_PKT), .TIMEOUT(TIMEOUT)) dut (
        .r_clk(r_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .tx_zlp(tx_zlp), .tx_ready(tx_ready), .busy(busy)
    );

    assign fifo_empty = (wr_ptr == rd_ptr);

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    // Queue model: registered read, flushed together with the block reset.
    always @(posedge r_clk) begin
        if (!rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            chk(!fifo_empty, "rd_en_while_empty", 32'(fifo_empty), 32'd0);
            if (!fifo_empty) begin
                fifo_data <= mem[rd_ptr & 4095];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge r_clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b0;
                1:       tx_ready = 1'b1;
                default: tx_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    logic       pend = 1'b0;
    logic [9:0] pend_v = '0;
    always @(negedge r_clk) begin
        logic [9:0] e;
        if (!rst) begin
            pend = 1'b0;
        end else begin
            if (pend)
                chk(tx_valid && {tx_zlp, tx_last, tx_data} == pend_v, "hold_stable",
                    {21'd0, tx_valid, tx_zlp, tx_last, tx_data}, {22'd1, pend_v});
            if (tx_valid)
                chk(!fifo_rd_en, "rd_during_send", 32'(fifo_rd_en), 32'd0);
            if (tx_valid && tx_ready) begin
                pend = 1'b0;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", {22'd0, tx_zlp, tx_last, tx_data}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("beat data=%02h last=%0b zlp=%0b (expected data=%02h last=%0b zlp=%0b)",
                             tx_data, tx_last, tx_zlp, e[7:0], e[8], e[9]);
                    chk({tx_zlp, tx_last, tx_data} == e, "beat",
                        {22'd0, tx_zlp, tx_last, tx_data}, {22'd0, e});
                end
            end else if (tx_valid) begin
                pend   = 1'b1;
                pend_v = {tx_zlp, tx_last, tx_data};
            end else begin
                pend = 1'b0;
            end
        end
    end

    // Whole burst sits in the queue at once, so packets are plain MAX_PKT chunks.
    task automatic push_bytes(input int n, input int base, input bit zlp_ok);
        logic [7:0] b;
        bit last;
        for (int i = 0; i < n; i++) begin
            b = (base >= 0) ? 8'(base + i) : 8'($urandom);
            mem[wr_ptr & 4095] = b;
            wr_ptr = wr_ptr + 1;
            last = ((i % MAX_PKT) == MAX_PKT - 1) || (i == n - 1);
            exp_q.push_back({1'b0, last, b});
        end
`ifdef QUEUE_PACKETIZER_ZLP_EN
        if (zlp_ok && (n % MAX_PKT) == 0) exp_q.push_back({1'b1, 1'b1, 8'h00});
`else
        if (zlp_ok && n < 0) exp_q.push_back({1'b1, 1'b1, 8'h00});
`endif
    endtask

    task automatic drain(input string nm);
        int i;
        i = 0;
        while (!(exp_q.size() == 0 && !busy && fifo_empty) && i < 20000) begin
            @(negedge r_clk);
            i++;
        end
        chk(i < 20000, nm, 32'(exp_q.size()), 32'd0);
        repeat (2 * TIMEOUT + 4) @(negedge r_clk);
    endtask

    task automatic latency(input int n, input int base, input int req);
        int t0, t1;
        ready_mode = 1;
        @(negedge r_clk);
        push_bytes(n, base, 1'b1);
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 200 && t1 < 0; i++) begin
            @(negedge r_clk);
            if (t0 < 0 && fifo_rd_en) t0 = i;
            if (t0 >= 0 && tx_valid) t1 = i;
        end
        chk(t0 >= 0 && t1 >= 0 && (t1 - t0) == req, "latency", 32'(t1 - t0), 32'(req));
        drain("latency_drain");
    endtask

    task automatic check_zero(input string nm);
        chk({fifo_rd_en, tx_valid, tx_data, tx_last, tx_zlp, busy} == '0, nm,
            {19'd0, fifo_rd_en, tx_valid, tx_data, tx_last, tx_zlp, busy}, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge r_clk);
        check_zero("reset_state");
        rst = 1'b1;
        repeat (2) @(negedge r_clk);

        latency(3, 8'hA1, 3);
        latency(1, -1, TIMEOUT + 2);

        ready_mode = 1;
        push_bytes(130, 0, 1'b1);
        drain("burst130_drain");

        // Backpressure: hold off the endpoint for 20 cycles.
        ready_mode = 0;
        push_bytes(5, -1, 1'b1);
        repeat (20) @(negedge r_clk);
        ready_mode = 1;
        drain("backpressure_drain");

        push_bytes(64, -1, 1'b1);
        drain("full64_drain");

        // A new byte arrives shortly after a full packet: no zero-length packet.
        push_bytes(64, -1, 1'b0);
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge r_clk);
        chk(exp_q.size() == 0, "gap_first_packet", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge r_clk);
        push_bytes(7, -1, 1'b1);
        drain("gap_drain");

        // Reset in the middle of a packet.
        push_bytes(40, -1, 1'b1);
        repeat (30) @(negedge r_clk);
        ready_mode = 0;
        repeat (3) @(negedge r_clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge r_clk);
        check_zero("midpkt_reset");
        rst = 1'b1;
        @(negedge r_clk);
        ready_mode = 1;
        push_bytes(70, -1, 1'b1);
        drain("post_reset_drain");

        ready_mode = 2;
        for (int k = 0; k < 6; k++) begin
            n = ($urandom_range(0, 2) == 0) ? MAX_PKT * int'($urandom_range(1, 2))
                                             : int'($urandom_range(1, 140));
            push_bytes(n, -1, 1'b1);
            drain("random_drain");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
